char_vram_writer: RTL and testbench

//  Terminal-style writer feeding the 80x60 text-mode char VRAM write port (addr/data/wea) consumed by the VGA text display.

---
 rtl/char_vram_writer_pkg.sv | 56 +++++
 rtl/char_vram_writer_cursor.sv | 86 ++++++++
 rtl/char_vram_writer.sv | 212 +++++++++++++++++++++
 tb/tb_char_vram_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_vram_writer_pkg.sv
// -----------------------------------------------------------------------------
// char_vram_writer_pkg
// Shared definitions for the terminal-style char VRAM writer:
//   - default screen geometry (80x60) and cursor/address field widths
//   - ASCII control constants (BS, LF, FF, CR, SPACE)
//   - FSM state encoding and cursor-counter operation codes
//   - VRAM address packing {row, col}
// Build option: TEXT_CURSOR_EN adds the CUR_DRAW / CUR_ERASE states.
// -----------------------------------------------------------------------------
package char_vram_writer_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;
  localparam int COL_W    = 7;
  localparam int ROW_W    = 6;
  localparam int ADDR_W   = ROW_W + COL_W;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_CLR_ROW   = 3'd2,
    ST_CLR_ALL   = 3'd3
`ifdef TEXT_CURSOR_EN
    ,
    ST_CUR_DRAW  = 3'd4,
    ST_CUR_ERASE = 3'd5
`endif
  } state_e;

  // Operations applied to the cursor counters for one clock.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,  // hold
    OP_INC  = 3'd1,  // advance col, wrap into next row (also the full-screen scan)
    OP_SCAN = 3'd2,  // advance col, wrap to 0 on the same row (row clear scan)
    OP_DEC  = 3'd3,  // backspace, saturates at col 0
    OP_CR   = 3'd4,  // col = 0
    OP_NL   = 3'd5,  // col = 0, row + 1 with wrap
    OP_HOME = 3'd6   // (0,0)
  } cursor_op_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_vram_writer_cursor.sv
// -----------------------------------------------------------------------------
// char_vram_writer_cursor
// Column/row counters for the text cursor. The same counters double as the
// scan position while a row or the whole screen is being cleared.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (cursor -> (0,0))
//   op_i         operation for this clock (cursor_op_e)
//   col_o/row_o  current cursor position
//   col_wrap_o   strobe: this clock's INC/SCAN wraps col from COLS-1 to 0
//   row_wrap_o   strobe: this clock's row step wraps row from ROWS-1 to 0
// -----------------------------------------------------------------------------
module char_vram_writer_cursor
  import char_vram_writer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cursor_op_e       op_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             col_wrap_o,
  output logic             row_wrap_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_at_last;
  logic             row_at_last;
  logic             row_step;

  assign col_at_last = (col_q == COL_LAST);
  assign row_at_last = (row_q == ROW_LAST);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    row_step = 1'b0;
    case (op_i)
      OP_INC: begin
        if (col_at_last) begin
          col_d    = '0;
          row_step = 1'b1;
        end else begin
          col_d = col_q + COL_ONE;
        end
      end
      OP_SCAN: col_d = col_at_last ? '0 : (col_q + COL_ONE);
      OP_DEC:  if (col_q != '0) col_d = col_q - COL_ONE;
      OP_CR:   col_d = '0;
      OP_NL: begin
        col_d    = '0;
        row_step = 1'b1;
      end
      OP_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      default: ;
    endcase
    // No scrolling: the screen is circular, so the last row steps back to 0.
    if (row_step) row_d = row_at_last ? '0 : (row_q + ROW_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign col_wrap_o = ((op_i == OP_INC) || (op_i == OP_SCAN)) && col_at_last;
  assign row_wrap_o = row_step && row_at_last;

endmodule

// File: rtl/char_vram_writer.sv
// -----------------------------------------------------------------------------
// char_vram_writer
// Terminal-style writer for the 80x60 text-mode char VRAM write port.
// Takes an ASCII byte stream over valid/ready, keeps a cursor, interprets
// CR / LF / BS / FF and issues at most one single-cycle VRAM write per clock.
// VRAM address = {row[5:0], col[6:0]}.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_ascii/in_valid     byte stream input
//   in_ready              high only in IDLE; transfer = in_valid & in_ready
//   vram_addr/vram_data   write port address/data (hold value when wea=0)
//   vram_wea              1-cycle write-enable pulse per write
//   cur_col/cur_row       cursor position
//   busy                  ~in_ready
// Build option: define TEXT_CURSOR_EN to draw CURSOR_CHAR at the cursor.
// -----------------------------------------------------------------------------
module char_vram_writer
  import char_vram_writer_pkg::*;
#(
  parameter int         COLS        = COLS_DEF,
  parameter int         ROWS        = ROWS_DEF,
  parameter int         CLR_ON_RST  = 1,
  parameter logic [7:0] CURSOR_CHAR = 8'h5F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_ascii,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic              vram_wea,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);

  localparam state_e RST_STATE = (CLR_ON_RST != 0) ? ST_CLR_ALL : ST_IDLE;
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  // Every path that returns to IDLE goes through this state first.
`ifdef TEXT_CURSOR_EN
  localparam state_e IDLE_ENTRY = ST_CUR_DRAW;
`else
  localparam state_e IDLE_ENTRY = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] vram_addr_q, addr_d;
  logic [7:0]        vram_data_q, data_d;
  logic              vram_wea_q, wea_d;

  cursor_op_e        cur_op;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              col_wrap;
  logic              row_wrap;

  // A CR/LF/BS that has been decoded and must now move the cursor.
  logic              ctrl_go;
  logic [7:0]        ctrl_code;

`ifdef TEXT_CURSOR_EN
  logic [7:0]        pend_q, pend_d;
`else
  logic              unused_cursor_char;
  assign unused_cursor_char = ^CURSOR_CHAR;
`endif

  char_vram_writer_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_i       (cur_op),
    .col_o      (col),
    .row_o      (row),
    .col_wrap_o (col_wrap),
    .row_wrap_o (row_wrap)
  );

  always_comb begin
    state_d = state_q;
    wea_d   = 1'b0;
    addr_d  = vram_addr_q;
    data_d  = vram_data_q;
    cur_op  = OP_NONE;
    ctrl_go = 1'b0;
`ifdef TEXT_CURSOR_EN
    pend_d    = pend_q;
    ctrl_code = pend_q;
`else
    ctrl_code = in_ascii;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_printable(in_ascii)) begin
            // Write is registered here so it appears one clock after transfer;
            // WRITE then advances the cursor.
            wea_d   = 1'b1;
            addr_d  = pack_addr(row, col);
            data_d  = in_ascii;
            state_d = ST_WRITE;
          end else if (in_ascii == ASCII_FF) begin
            cur_op  = OP_HOME;
            state_d = ST_CLR_ALL;
          end else if ((in_ascii == ASCII_CR) || (in_ascii == ASCII_LF) ||
                       ((in_ascii == ASCII_BS) && (col != '0))) begin
`ifdef TEXT_CURSOR_EN
            pend_d  = in_ascii;
            state_d = ST_CUR_ERASE;
`else
            ctrl_go = 1'b1;
`endif
          end
          // Anything else (incl. BS at col 0) is consumed and dropped.
        end
      end
      ST_WRITE: begin
        cur_op  = OP_INC;
        state_d = col_wrap ? ST_CLR_ROW : IDLE_ENTRY;
      end
      ST_CLR_ROW: begin
        wea_d  = 1'b1;
        addr_d = pack_addr(row, col);
        data_d = ASCII_SPACE;
        cur_op = OP_SCAN;
        if (col_wrap) state_d = IDLE_ENTRY;
      end
      ST_CLR_ALL: begin
        // Raster scan on the cursor counters; finishing the last cell wraps
        // them back to (0,0), which is where the cursor must end up.
        wea_d  = 1'b1;
        addr_d = pack_addr(row, col);
        data_d = ASCII_SPACE;
        cur_op = OP_INC;
        if (row_wrap) state_d = IDLE_ENTRY;
      end
`ifdef TEXT_CURSOR_EN
      ST_CUR_DRAW: begin
        wea_d   = 1'b1;
        addr_d  = pack_addr(row, col);
        data_d  = CURSOR_CHAR;
        state_d = ST_IDLE;
      end
      ST_CUR_ERASE: begin
        wea_d   = 1'b1;
        addr_d  = pack_addr(row, col);
        data_d  = ASCII_SPACE;
        ctrl_go = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (ctrl_go) begin
      case (ctrl_code)
        ASCII_CR: begin
          cur_op  = OP_CR;
          state_d = IDLE_ENTRY;
        end
        ASCII_LF: begin
          cur_op  = OP_NL;
          state_d = ST_CLR_ROW;
        end
        ASCII_BS: begin
          cur_op  = OP_DEC;
          state_d = IDLE_ENTRY;
`ifndef TEXT_CURSOR_EN
          // With the cursor glyph enabled the following CUR_DRAW covers this cell.
          wea_d  = 1'b1;
          addr_d = pack_addr(row, col - COL_ONE);
          data_d = ASCII_SPACE;
`endif
        end
        default: state_d = IDLE_ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      vram_wea_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vram_addr_q <= addr_d;
      vram_data_q <= data_d;
      vram_wea_q  <= wea_d;
    end
  end

`ifdef TEXT_CURSOR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign vram_addr = vram_addr_q;
  assign vram_data = vram_data_q;
  assign vram_wea  = vram_wea_q;
  assign cur_col   = col;
  assign cur_row   = row;

endmodule

// File: tb/tb_char_vram_writer.sv
// -----------------------------------------------------------------------------
// tb_char_vram_writer
// Directed, table-driven bench for char_vram_writer in its default build
// (no cursor glyph), 80x60 screen, clear-on-reset enabled.
// -----------------------------------------------------------------------------
module tb_char_vram_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_ascii = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_wea;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy;

  char_vram_writer #(
    .COLS        (80),
    .ROWS        (60),
    .CLR_ON_RST  (1),
    .CURSOR_CHAR (8'h5F)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ascii  (in_ascii),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .vram_wea  (vram_wea),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge.
  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) begin
    if (vram_wea) wq.push_back('{addr: vram_addr, data: vram_data});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("idle_within_bound", 32'(ok), 32'd1);
    tick();
    tick();
  endtask

  // Present a byte and wait (bounded) for its transfer edge; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    bit ok;
    ok       = 1'b0;
    in_ascii = b;
    in_valid = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!keep_valid) in_valid = 1'b0;
    if (!ok) check("send_accepted", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        exp_wr;
    logic [12:0] exp_addr;
    logic [7:0]  exp_data;
    logic [6:0]  exp_col;
    logic [5:0]  exp_row;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int mark;
    int n;
    int bad;
    int cnt;
    int zc;
    logic [7:0] eb;

    // Applied in order from cursor (0,0); each row is cumulative.
    vecs[0]  = '{8'h41, 1'b1, 13'h0000, 8'h41, 7'd1, 6'd0};  // 'A'
    vecs[1]  = '{8'h42, 1'b1, 13'h0001, 8'h42, 7'd2, 6'd0};  // 'B'
    vecs[2]  = '{8'h43, 1'b1, 13'h0002, 8'h43, 7'd3, 6'd0};  // 'C'
    vecs[3]  = '{8'h08, 1'b1, 13'h0002, 8'h20, 7'd2, 6'd0};  // BS at col 3
    vecs[4]  = '{8'h0D, 1'b0, 13'h0000, 8'h00, 7'd0, 6'd0};  // CR
    vecs[5]  = '{8'h08, 1'b0, 13'h0000, 8'h00, 7'd0, 6'd0};  // BS at col 0
    vecs[6]  = '{8'h01, 1'b0, 13'h0000, 8'h00, 7'd0, 6'd0};  // ignored
    vecs[7]  = '{8'h7E, 1'b1, 13'h0000, 8'h7E, 7'd1, 6'd0};  // '~' last printable
    vecs[8]  = '{8'h7F, 1'b0, 13'h0000, 8'h00, 7'd1, 6'd0};  // DEL ignored
    vecs[9]  = '{8'h1B, 1'b0, 13'h0000, 8'h00, 7'd1, 6'd0};  // ESC ignored
    vecs[10] = '{8'h20, 1'b1, 13'h0001, 8'h20, 7'd2, 6'd0};  // space printable

    // ---------------- reset values ----------------
    tick();
    tick();
    check("rst_wea", 32'(vram_wea), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    check("rst_data", 32'(vram_data), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // ---------------- clear after reset ----------------
    rst_n = 1'b1;
    mark  = wq.size();
    wait_idle(6000);
    n = wq.size() - mark;
    check("clr_rst_count", 32'(n), 32'd4800);
    bad = 0;
    for (int i = 0; i < n && i < 4800; i++) begin
      if (wq[mark+i].addr !== {6'(i / 80), 7'(i % 80)} || wq[mark+i].data !== 8'h20) bad++;
    end
    check("clr_rst_raster", 32'(bad), 32'd0);
    if (n > 0) check("clr_rst_last_addr", 32'(wq[wq.size()-1].addr), 32'h1DCF);
    check("clr_rst_ready", 32'(in_ready), 32'd1);
    $display("[TB] reset clear: %0d writes, in_ready=%0d", n, in_ready);

    // ---------------- table vectors ----------------
    for (int v = 0; v < 11; v++) begin
      mark = wq.size();
      send_byte(vecs[v].b, 1'b0);
      tick();
      check($sformatf("vec%0d_latency_wea", v), 32'(vram_wea), 32'(vecs[v].exp_wr));
      wait_idle(200);
      n = wq.size() - mark;
      check($sformatf("vec%0d_nwrites", v), 32'(n), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr && n > 0) begin
        check($sformatf("vec%0d_addr", v), 32'(wq[mark].addr), 32'(vecs[v].exp_addr));
        check($sformatf("vec%0d_data", v), 32'(wq[mark].data), 32'(vecs[v].exp_data));
      end
      check($sformatf("vec%0d_col", v), 32'(cur_col), 32'(vecs[v].exp_col));
      check($sformatf("vec%0d_row", v), 32'(cur_row), 32'(vecs[v].exp_row));
      $display("[TB] vec %0d: byte %02h -> %0d write(s), cursor (%0d,%0d)",
               v, vecs[v].b, n, cur_col, cur_row);
    end

    // ---------------- 80 printables fill row 0, then row 1 cleared ----------------
    send_byte(8'h0D, 1'b0);
    wait_idle(50);
    mark = wq.size();
    for (int k = 0; k < 80; k++) send_byte(8'(8'h41 + (k % 26)), 1'b0);
    wait_idle(200);
    n = wq.size() - mark;
    check("row_fill_count", 32'(n), 32'd160);
    bad = 0;
    for (int k = 0; k < 80 && k < n; k++) begin
      eb = 8'(8'h41 + (k % 26));
      if (wq[mark+k].addr !== 13'(k) || wq[mark+k].data !== eb) bad++;
    end
    check("row_fill_chars", 32'(bad), 32'd0);
    if (n >= 80) check("row_fill_last_addr", 32'(wq[mark+79].addr), 32'h004F);
    bad = 0;
    for (int k = 80; k < 160 && k < n; k++) begin
      if (wq[mark+k].addr !== 13'(13'h0080 + (k - 80)) || wq[mark+k].data !== 8'h20) bad++;
    end
    check("row_fill_clr_row1", 32'(bad), 32'd0);
    check("row_fill_col", 32'(cur_col), 32'd0);
    check("row_fill_row", 32'(cur_row), 32'd1);
    $display("[TB] row fill: %0d writes, cursor (%0d,%0d)", n, cur_col, cur_row);

    // ---------------- in_valid held through CLR_ROW ----------------
    mark = wq.size();
    send_byte(8'h0A, 1'b1);
    in_ascii = 8'h5A;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (in_ready) break;
      cnt++;
    end
    check("held_busy_cycles", 32'(cnt), 32'd80);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle(50);
    n = wq.size() - mark;
    check("held_count", 32'(n), 32'd81);
    zc = 0;
    for (int k = 0; k < n; k++) if (wq[mark+k].data === 8'h5A) zc++;
    check("held_z_once", 32'(zc), 32'd1);
    if (n > 0) check("held_z_addr", 32'(wq[wq.size()-1].addr), 32'h0100);
    if (n > 0) check("held_first_clr", 32'(wq[mark].addr), 32'h0100);
    check("held_col", 32'(cur_col), 32'd1);
    check("held_row", 32'(cur_row), 32'd2);
    $display("[TB] held valid: busy %0d cycles, %0d writes, cursor (%0d,%0d)",
             cnt, n, cur_col, cur_row);

    // ---------------- FF, walk to (5,59), LF wraps to row 0 ----------------
    mark = wq.size();
    send_byte(8'h0C, 1'b0);
    wait_idle(6000);
    n = wq.size() - mark;
    check("ff_count", 32'(n), 32'd4800);
    check("ff_col", 32'(cur_col), 32'd0);
    check("ff_row", 32'(cur_row), 32'd0);
    $display("[TB] form feed: %0d writes, cursor (%0d,%0d)", n, cur_col, cur_row);
    for (int k = 0; k < 59; k++) begin
      send_byte(8'h0A, 1'b0);
      wait_idle(200);
    end
    mark = wq.size();
    for (int k = 0; k < 5; k++) send_byte(8'(8'h30 + k), 1'b0);
    wait_idle(50);
    if (wq.size() > mark) check("walk_last_addr", 32'(wq[wq.size()-1].addr), 32'h1D84);
    check("walk_col", 32'(cur_col), 32'd5);
    check("walk_row", 32'(cur_row), 32'd59);
    mark = wq.size();
    send_byte(8'h0A, 1'b0);
    wait_idle(200);
    n = wq.size() - mark;
    check("wrap_count", 32'(n), 32'd80);
    bad = 0;
    for (int k = 0; k < n && k < 80; k++) begin
      if (wq[mark+k].addr !== 13'(k) || wq[mark+k].data !== 8'h20) bad++;
    end
    check("wrap_row0_clear", 32'(bad), 32'd0);
    check("wrap_col", 32'(cur_col), 32'd0);
    check("wrap_row", 32'(cur_row), 32'd0);
    $display("[TB] LF at row 59: %0d writes, cursor (%0d,%0d)", n, cur_col, cur_row);

    // ---------------- reset mid CLR_ALL ----------------
    send_byte(8'h0C, 1'b0);
    for (int i = 0; i < 100; i++) tick();
    check("midrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wea", 32'(vram_wea), 32'd0);
    check("midrst_addr", 32'(vram_addr), 32'd0);
    check("midrst_data", 32'(vram_data), 32'd0);
    check("midrst_col", 32'(cur_col), 32'd0);
    check("midrst_row", 32'(cur_row), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    mark = wq.size();
    wait_idle(6000);
    n = wq.size() - mark;
    check("midrst_clr_count", 32'(n), 32'd4800);
    if (n > 0) check("midrst_first_addr", 32'(wq[mark].addr), 32'h0000);
    bad = 0;
    for (int i = 0; i < n && i < 4800; i++) begin
      if (wq[mark+i].addr !== {6'(i / 80), 7'(i % 80)} || wq[mark+i].data !== 8'h20) bad++;
    end
    check("midrst_raster", 32'(bad), 32'd0);
    $display("[TB] reset mid-clear: restart with %0d writes", n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
